// File: rtl/u_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : u_pkg
//  Description : Shared widths and the write-back entry type for u_wb_pipe.
//  Revision    : 1.0 - initial release
// ============================================================================
package u_pkg;

    localparam int XLEN = 32;
    localparam int AW   = 5;

    typedef struct packed {
        logic            valid;
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] data;
    } wb_ent_t;

endpackage
`default_nettype wire

// File: rtl/u_fwd_sel.sv
`default_nettype none
// ============================================================================
//  Module      : u_fwd_sel
//  Description : Youngest-first priority matcher selecting a forwarded operand.
//  Revision    : 1.0 - initial release
// ============================================================================
module u_fwd_sel #(
    parameter int XLEN   = u_pkg::XLEN,
    parameter int AW     = u_pkg::AW,
    parameter int DEPTH  = 3,
    parameter bit FWD_EN = 1'b1
) (
    input  logic [DEPTH-1:0]      i_vld,
    input  logic [DEPTH*AW-1:0]   i_addr,
    input  logic [DEPTH*XLEN-1:0] i_data,
    input  logic [AW-1:0]         i_rs_a,
    input  logic [XLEN-1:0]       i_rf_d,
    output logic [XLEN-1:0]       o_fwd,
    output logic                  o_hit
);

    logic            w_hit;
    logic [XLEN-1:0] w_sel;

    always_comb begin
        w_hit = 1'b0;
        w_sel = i_rf_d;
        if (FWD_EN && (i_rs_a != '0)) begin
            // Stage 0 is the youngest entry, so the first match scanning upward wins.
            for (int k = 0; k < DEPTH; k++) begin
                if (!w_hit && i_vld[k] && (i_addr[k*AW +: AW] == i_rs_a)) begin
                    w_hit = 1'b1;
                    w_sel = i_data[k*XLEN +: XLEN];
                end
            end
        end
    end

    assign o_hit = w_hit;
    assign o_fwd = (i_rs_a == '0) ? '0 : w_sel;

endmodule
`default_nettype wire

// File: rtl/u_wb_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : u_wb_pipe
//  Description : Register-file write-back delay pipeline with operand forwarding.
//  Revision    : 1.0 - initial release
// ============================================================================
module u_wb_pipe #(
    parameter int XLEN   = u_pkg::XLEN,
    parameter int AW     = u_pkg::AW,
    parameter int DEPTH  = 3,
    parameter bit FWD_EN = 1'b1
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       push_we,
    input  logic [AW-1:0]              push_a,
    input  logic [XLEN-1:0]            push_d,
    input  logic                       hold,
    input  logic                       flush,
    input  logic [AW-1:0]              rs1_a,
    input  logic [AW-1:0]              rs2_a,
    input  logic [XLEN-1:0]            rf_rs1_o,
    input  logic [XLEN-1:0]            rf_rs2_o,
    output logic [XLEN-1:0]            fwd_o1,
    output logic [XLEN-1:0]            fwd_o2,
    output logic                       fwd_hit1,
    output logic                       fwd_hit2,
    output logic                       rf_rd_e,
    output logic [AW-1:0]              rf_rd_a,
    output logic [XLEN-1:0]            rf_rd_i,
    output logic [$clog2(DEPTH+1)-1:0] occ,
    output logic                       busy
);

    localparam int OW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0]      r_vld;
    logic [AW-1:0]         r_addr [DEPTH];
    logic [XLEN-1:0]       r_data [DEPTH];
    logic [OW-1:0]         r_occ;

    logic                  w_push_v;
    logic [OW-1:0]         w_occ_nxt;
    logic [DEPTH*AW-1:0]   w_addr_flat;
    logic [DEPTH*XLEN-1:0] w_data_flat;

    // Writes to x0 are architecturally void, so they never occupy a stage.
    assign w_push_v = push_we & (push_a != '0);

    always_comb begin
        w_occ_nxt = OW'(w_push_v);
        for (int k = 0; k < DEPTH - 1; k++) begin
            w_occ_nxt = w_occ_nxt + OW'(r_vld[k]);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_vld <= '0;
            r_occ <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                r_addr[k] <= '0;
                r_data[k] <= '0;
            end
        end else if (flush) begin
            r_vld <= '0;
            r_occ <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                r_addr[k] <= '0;
                r_data[k] <= '0;
            end
        end else if (!hold) begin
            r_vld[0]  <= w_push_v;
            r_addr[0] <= w_push_v ? push_a : '0;
            r_data[0] <= w_push_v ? push_d : '0;
            for (int k = 1; k < DEPTH; k++) begin
                r_vld[k]  <= r_vld[k-1];
                r_addr[k] <= r_addr[k-1];
                r_data[k] <= r_data[k-1];
            end
            r_occ <= w_occ_nxt;
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_flat
        assign w_addr_flat[g*AW +: AW]     = r_addr[g];
        assign w_data_flat[g*XLEN +: XLEN] = r_data[g];
    end

    u_fwd_sel #(
        .XLEN   (XLEN),
        .AW     (AW),
        .DEPTH  (DEPTH),
        .FWD_EN (FWD_EN)
    ) u_fwd1 (
        .i_vld  (r_vld),
        .i_addr (w_addr_flat),
        .i_data (w_data_flat),
        .i_rs_a (rs1_a),
        .i_rf_d (rf_rs1_o),
        .o_fwd  (fwd_o1),
        .o_hit  (fwd_hit1)
    );

    u_fwd_sel #(
        .XLEN   (XLEN),
        .AW     (AW),
        .DEPTH  (DEPTH),
        .FWD_EN (FWD_EN)
    ) u_fwd2 (
        .i_vld  (r_vld),
        .i_addr (w_addr_flat),
        .i_data (w_data_flat),
        .i_rs_a (rs2_a),
        .i_rf_d (rf_rs2_o),
        .o_fwd  (fwd_o2),
        .o_hit  (fwd_hit2)
    );

    // Suppressing the write under hold keeps the oldest result from landing twice.
    assign rf_rd_e = r_vld[DEPTH-1] & ~hold;
    assign rf_rd_a = r_addr[DEPTH-1];
    assign rf_rd_i = r_data[DEPTH-1];
    assign occ     = r_occ;
    assign busy    = (r_occ != '0);

endmodule
`default_nettype wire

// File: tb/tb_u_wb_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_u_wb_pipe
//  Description : Directed self-checking bench for u_wb_pipe (DEPTH=3, both FWD_EN).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_u_wb_pipe;

    logic        clk;
    logic        rstn;
    logic        push_we;
    logic [4:0]  push_a;
    logic [31:0] push_d;
    logic        hold;
    logic        flush;
    logic [4:0]  rs1_a;
    logic [4:0]  rs2_a;
    logic [31:0] rf_rs1_o;
    logic [31:0] rf_rs2_o;

    logic [31:0] fwd_o1, fwd_o2, nf_fwd_o1, nf_fwd_o2;
    logic        fwd_hit1, fwd_hit2, nf_fwd_hit1, nf_fwd_hit2;
    logic        rf_rd_e, nf_rf_rd_e;
    logic [4:0]  rf_rd_a, nf_rf_rd_a;
    logic [31:0] rf_rd_i, nf_rf_rd_i;
    logic [1:0]  occ, nf_occ;
    logic        busy, nf_busy;

    int n_vec  = 0;
    int n_miss = 0;

    u_wb_pipe #(.XLEN(32), .AW(5), .DEPTH(3), .FWD_EN(1'b1)) dut (
        .clk(clk), .rstn(rstn), .push_we(push_we), .push_a(push_a), .push_d(push_d),
        .hold(hold), .flush(flush), .rs1_a(rs1_a), .rs2_a(rs2_a),
        .rf_rs1_o(rf_rs1_o), .rf_rs2_o(rf_rs2_o),
        .fwd_o1(fwd_o1), .fwd_o2(fwd_o2), .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2),
        .rf_rd_e(rf_rd_e), .rf_rd_a(rf_rd_a), .rf_rd_i(rf_rd_i), .occ(occ), .busy(busy)
    );

    u_wb_pipe #(.XLEN(32), .AW(5), .DEPTH(3), .FWD_EN(1'b0)) dut_nf (
        .clk(clk), .rstn(rstn), .push_we(push_we), .push_a(push_a), .push_d(push_d),
        .hold(hold), .flush(flush), .rs1_a(rs1_a), .rs2_a(rs2_a),
        .rf_rs1_o(rf_rs1_o), .rf_rs2_o(rf_rs2_o),
        .fwd_o1(nf_fwd_o1), .fwd_o2(nf_fwd_o2), .fwd_hit1(nf_fwd_hit1), .fwd_hit2(nf_fwd_hit2),
        .rf_rd_e(nf_rf_rd_e), .rf_rd_a(nf_rf_rd_a), .rf_rd_i(nf_rf_rd_i), .occ(nf_occ), .busy(nf_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
        end
    endtask

    // Cycle c starts 1 time unit after a rising edge; outputs are sampled on the falling edge.
    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic idle_in();
        push_we = 1'b0;
        push_a  = '0;
        push_d  = '0;
        hold    = 1'b0;
        flush   = 1'b0;
    endtask

    task automatic push(input logic [4:0] a, input logic [31:0] d);
        push_we = 1'b1;
        push_a  = a;
        push_d  = d;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b0;
        idle_in();
        rs1_a    = 5'd1;
        rs2_a    = 5'd0;
        rf_rs1_o = 32'hCAFE0001;
        rf_rs2_o = 32'h55;
        #12;
        chk("rst_rd_e",  rf_rd_e,  0);
        chk("rst_rd_a",  rf_rd_a,  0);
        chk("rst_rd_i",  rf_rd_i,  0);
        chk("rst_occ",   occ,      0);
        chk("rst_busy",  busy,     0);
        chk("rst_hit1",  fwd_hit1, 0);
        chk("rst_o1",    fwd_o1,   32'hCAFE0001);
        chk("rst_o2_x0", fwd_o2,   0);
        nxt();
        rstn = 1'b1;
        nxt();

        // S1: single push of x5, written exactly in cycle 3
        nxt(); push(5'd5, 32'hDEADBEEF); smp();
        chk("s1_e_c0", rf_rd_e, 0);
        for (int c = 1; c <= 4; c++) begin
            nxt(); idle_in(); smp();
            chk($sformatf("s1_e_c%0d", c),   rf_rd_e, (c == 3) ? 1 : 0);
            chk($sformatf("s1_occ_c%0d", c), occ,     (c <= 3) ? 1 : 0);
            chk($sformatf("s1_busy_c%0d", c), busy,   (c <= 3) ? 1 : 0);
            if (c == 3) begin
                chk("s1_a", rf_rd_a, 5);
                chk("s1_d", rf_rd_i, 32'hDEADBEEF);
            end
        end

        // S2: two writes to x7, youngest forwarded; FWD_EN=0 copy passes regfile through
        rs1_a = 5'd7; rf_rs1_o = 32'h99;
        nxt(); push(5'd7, 32'h11); smp();
        chk("s2_hit_c0", fwd_hit1, 0);
        nxt(); push(5'd7, 32'h22); smp();
        chk("s2_o1_c1", fwd_o1, 32'h11);
        nxt(); idle_in(); smp();
        chk("s2_o1_c2",   fwd_o1,      32'h22);
        chk("s2_hit_c2",  fwd_hit1,    1);
        chk("s2_nf_o1",   nf_fwd_o1,   32'h99);
        chk("s2_nf_hit1", nf_fwd_hit1, 0);
        nxt(); smp();
        chk("s2_e_c3",  rf_rd_e, 1);
        chk("s2_d_c3",  rf_rd_i, 32'h11);
        chk("s2_o1_c3", fwd_o1,  32'h22);
        nxt(); smp();
        chk("s2_d_c4",  rf_rd_i, 32'h22);
        chk("s2_o1_c4", fwd_o1,  32'h22);
        nxt(); smp();
        chk("s2_o1_c5",  fwd_o1,   32'h99);
        chk("s2_hit_c5", fwd_hit1, 0);
        chk("s2_e_c5",   rf_rd_e,  0);

        // S3: push to x0 never occupies the pipe; rs2=x0 reads as zero
        rs2_a = 5'd0; rf_rs2_o = 32'h55;
        nxt(); push(5'd0, 32'h1234); smp();
        for (int c = 1; c <= 4; c++) begin
            nxt(); idle_in(); smp();
            chk($sformatf("s3_e_c%0d", c),   rf_rd_e,  0);
            chk($sformatf("s3_occ_c%0d", c), occ,      0);
            chk($sformatf("s3_o2_c%0d", c),  fwd_o2,   0);
            chk($sformatf("s3_h2_c%0d", c),  fwd_hit2, 0);
        end

        // S4: x3 reaches the last stage in cycle 3, held for cycles 3-5 -> written once in cycle 6
        rs1_a = 5'd3; rf_rs1_o = 32'h77; rs2_a = 5'd9; rf_rs2_o = 32'h90;
        nxt(); push(5'd3, 32'hA); smp();
        for (int c = 1; c <= 7; c++) begin
            nxt(); idle_in();
            hold = (c >= 3 && c <= 5);
            if (c == 4) push(5'd9, 32'h999);
            smp();
            chk($sformatf("s4_e_c%0d", c),   rf_rd_e,  (c == 6) ? 1 : 0);
            chk($sformatf("s4_h1_c%0d", c),  fwd_hit1, (c <= 6) ? 1 : 0);
            chk($sformatf("s4_o1_c%0d", c),  fwd_o1,   (c <= 6) ? 32'hA : 32'h77);
            chk($sformatf("s4_occ_c%0d", c), occ,      (c <= 6) ? 1 : 0);
            chk($sformatf("s4_h2_c%0d", c),  fwd_hit2, 0);
        end

        // S5: flush with oldest in the last stage; its write still happens, pushed x6 dropped
        rs1_a = 5'd4; rf_rs1_o = 32'h44; rs2_a = 5'd6; rf_rs2_o = 32'h66;
        nxt(); push(5'd1, 32'h101); smp();
        nxt(); push(5'd2, 32'h202); smp();
        nxt(); push(5'd4, 32'h404); smp();
        nxt(); push(5'd6, 32'h606); flush = 1'b1; smp();
        chk("s5_e_c3",  rf_rd_e, 1);
        chk("s5_a_c3",  rf_rd_a, 1);
        chk("s5_d_c3",  rf_rd_i, 32'h101);
        chk("s5_occ3",  occ,     3);
        chk("s5_o1_c3", fwd_o1,  32'h404);
        for (int c = 4; c <= 6; c++) begin
            nxt(); idle_in(); smp();
            chk($sformatf("s5_e_c%0d", c),    rf_rd_e,  0);
            chk($sformatf("s5_occ_c%0d", c),  occ,      0);
            chk($sformatf("s5_busy_c%0d", c), busy,     0);
            chk($sformatf("s5_h1_c%0d", c),   fwd_hit1, 0);
            chk($sformatf("s5_h2_c%0d", c),   fwd_hit2, 0);
        end

        // S5b: flush wins over hold
        rs1_a = 5'd2; rf_rs1_o = 32'h22;
        nxt(); push(5'd2, 32'h2); smp();
        nxt(); idle_in(); hold = 1'b1; flush = 1'b1; smp();
        chk("s5b_occ_c1", occ, 1);
        nxt(); idle_in(); smp();
        chk("s5b_occ_c2", occ,      0);
        chk("s5b_h1_c2",  fwd_hit1, 0);

        // S6: asynchronous reset between edges with two results in flight
        rs1_a = 5'd8; rf_rs1_o = 32'h88;
        nxt(); push(5'd8, 32'h808); smp();
        nxt(); push(5'd9, 32'h909); smp();
        nxt(); idle_in(); smp();
        chk("s6_occ_pre", occ,    2);
        chk("s6_o1_pre",  fwd_o1, 32'h808);
        #2;
        rstn = 1'b0;
        #1;
        chk("s6_occ_rst",  occ,      0);
        chk("s6_busy_rst", busy,     0);
        chk("s6_h1_rst",   fwd_hit1, 0);
        chk("s6_o1_rst",   fwd_o1,   32'h88);
        chk("s6_e_rst",    rf_rd_e,  0);
        chk("s6_a_rst",    rf_rd_a,  0);
        #1;
        rstn = 1'b1;
        for (int c = 3; c <= 6; c++) begin
            nxt(); smp();
            chk($sformatf("s6_e_c%0d", c),   rf_rd_e, 0);
            chk($sformatf("s6_occ_c%0d", c), occ,     0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
